pid_core: RTL and testbench



---
 rtl/pid_pkg.sv | 40 ++++
 rtl/pid_mac.sv | 38 +++
 rtl/pid_core.sv | 161 ++++++++++++++++
 tb/tb_pid_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types, default widths and the saturating-clip helper for the PID core.
package pid_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  // Width of the intermediate used by sat_s; every clipped quantity must fit in it.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL_P,
    MUL_I,
    MUL_D,
    SUM
  } pid_state_e;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HIGH,
    SAT_LOW
  } sat_flag_e;

  // Clip a signed value to the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat_s(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Registered signed multiply-accumulate shared by the P, I and D terms.
module pid_mac
  import pid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAC_W  = 2 * DATA_W_DEF + 2
) (
  input  logic                     clk_in,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic                     acc_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [MAC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [MAC_W-1:0]    prod_ext;
  logic signed [MAC_W-1:0]    acc_d;
  logic signed [MAC_W-1:0]    acc_q;

  assign prod     = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
  assign prod_ext = MAC_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)       acc_d = '0;
    else if (load_i) acc_d = prod_ext;
    else if (acc_i)  acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk_in) begin
    acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pid_core.sv
// Fixed-point PID controller with one shared multiplier sequenced by an FSM.
// Optional conditional-integration anti-windup: define PID_ANTIWINDUP_EN.
module pid_core
  import pid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] kp,
  input  logic signed [DATA_W-1:0] ki,
  input  logic signed [DATA_W-1:0] kd,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] meas,
  input  logic                     meas_valid,
  output logic signed [DATA_W-1:0] u_out,
  output logic                     u_valid,
  output logic                     busy,
  output pid_state_e               dbg_state_o,
  output logic signed [ACC_W-1:0]  dbg_i_acc_o
);

  localparam int MAC_W = 2 * DATA_W + 2;

  // Handshake: meas_valid is a one-cycle strobe with no back-pressure; it is
  // accepted only in IDLE with enable high, otherwise dropped. u_valid is a
  // one-cycle pulse six cycles after an accepted strobe; u_out holds between pulses.

  pid_state_e               state_q;
  logic signed [DATA_W-1:0] sp_q, meas_q, kp_q, ki_q, kd_q;
  logic signed [DATA_W-1:0] e_q, d_q, e_prev_q, u_q;
  logic signed [ACC_W-1:0]  i_acc_q;
  logic                     u_valid_q, busy_q;

  logic signed [DATA_W:0]   e_wide, d_wide;
  logic signed [ACC_W:0]    i_wide;
  logic signed [DATA_W-1:0] e_now, d_now, i_mul, y_now;
  logic signed [ACC_W-1:0]  i_next;
  logic signed [MAC_W-1:0]  mac_acc, y_shift;
  logic                     int_hold;

  logic                     mac_clr, mac_load, mac_acc_en;
  logic signed [DATA_W-1:0] mac_a, mac_b;

  always_comb begin
    e_wide  = (DATA_W+1)'(sp_q) - (DATA_W+1)'(meas_q);
    e_now   = DATA_W'(sat_s(SAT_W'(e_wide), DATA_W));
    d_wide  = (DATA_W+1)'(e_now) - (DATA_W+1)'(e_prev_q);
    d_now   = DATA_W'(sat_s(SAT_W'(d_wide), DATA_W));
    i_wide  = (ACC_W+1)'(i_acc_q) + (ACC_W+1)'(e_now);
    i_next  = ACC_W'(sat_s(SAT_W'(i_wide), ACC_W));
    i_mul   = DATA_W'(sat_s(SAT_W'(i_acc_q), DATA_W));
    y_shift = mac_acc >>> FRAC_W;
    y_now   = DATA_W'(sat_s(SAT_W'(y_shift), DATA_W));
  end

`ifdef PID_ANTIWINDUP_EN
  sat_flag_e sat_q;
  // Stop integrating further into a rail the last output already hit.
  assign int_hold = ((sat_q == SAT_HIGH) && (e_now > 0)) ||
                    ((sat_q == SAT_LOW)  && (e_now < 0));
`else
  assign int_hold = 1'b0;
`endif

  always_comb begin
    mac_a      = '0;
    mac_b      = '0;
    mac_load   = 1'b0;
    mac_acc_en = 1'b0;
    case (state_q)
      MUL_P: begin mac_a = kp_q; mac_b = e_q;   mac_load   = 1'b1; end
      MUL_I: begin mac_a = ki_q; mac_b = i_mul; mac_acc_en = 1'b1; end
      MUL_D: begin mac_a = kd_q; mac_b = d_q;   mac_acc_en = 1'b1; end
      default: ;
    endcase
  end

  assign mac_clr = reset || !enable;

  pid_mac #(
    .DATA_W (DATA_W),
    .MAC_W  (MAC_W)
  ) u_mac (
    .clk_in (clk_in),
    .clr_i  (mac_clr),
    .load_i (mac_load),
    .acc_i  (mac_acc_en),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .acc_o  (mac_acc)
  );

  always_ff @(posedge clk_in) begin
    if (reset || !enable) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      meas_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      e_q       <= '0;
      d_q       <= '0;
      e_prev_q  <= '0;
      i_acc_q   <= '0;
      u_q       <= '0;
      u_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PID_ANTIWINDUP_EN
      sat_q     <= SAT_NONE;
`endif
    end else begin
      u_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (meas_valid) begin
            sp_q    <= setpoint;
            meas_q  <= meas;
            kp_q    <= kp;
            ki_q    <= ki;
            kd_q    <= kd;
            busy_q  <= 1'b1;
            state_q <= ERR;
          end
        end
        ERR: begin
          e_q      <= e_now;
          d_q      <= d_now;
          e_prev_q <= e_now;
          if (!int_hold) i_acc_q <= i_next;
          state_q  <= MUL_P;
        end
        MUL_P: state_q <= MUL_I;
        MUL_I: state_q <= MUL_D;
        MUL_D: state_q <= SUM;
        SUM: begin
          u_q       <= y_now;
          u_valid_q <= 1'b1;
          busy_q    <= 1'b0;
`ifdef PID_ANTIWINDUP_EN
          if (MAC_W'(y_now) == y_shift) sat_q <= SAT_NONE;
          else if (y_shift[MAC_W-1])    sat_q <= SAT_LOW;
          else                          sat_q <= SAT_HIGH;
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign u_out       = u_q;
  assign u_valid     = u_valid_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_i_acc_o = i_acc_q;

endmodule

// File: tb/tb_pid_core.sv
// Directed self-checking bench for pid_core; expectations are hand-computed Q8.8 results.
module tb_pid_core;
  import pid_pkg::*;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] kp, ki, kd, setpoint, meas;
  logic               meas_valid;
  logic signed [15:0] u_out;
  logic               u_valid, busy;
  pid_state_e         dbg_state;
  logic signed [31:0] dbg_i_acc;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  pid_core dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .kp          (kp),
    .ki          (ki),
    .kd          (kd),
    .setpoint    (setpoint),
    .meas        (meas),
    .meas_valid  (meas_valid),
    .u_out       (u_out),
    .u_valid     (u_valid),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_i_acc_o (dbg_i_acc)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_gains(input logic signed [15:0] p, input logic signed [15:0] i,
                           input logic signed [15:0] d);
    kp = p; ki = i; kd = d;
  endtask

  task automatic clear_ctrl();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  // Strobe one sample in the current cycle (cycle 0); wait for u_valid up to 20 cycles.
  task automatic sample(input logic signed [15:0] sp, input logic signed [15:0] m,
                        output logic signed [15:0] u, output int lat);
    setpoint   = sp;
    meas       = m;
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    lat = -1;
    u   = 'x;
    for (int c = 1; c <= 20; c++) begin
      if (u_valid) begin
        lat = c;
        u   = u_out;
        break;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; meas_valid = 1'b0;
    set_gains(16'sh0100, 16'sh0000, 16'sh0000);
    setpoint = 16'sd0; meas = 16'sd0;
    repeat (3) tick();
    total++; if (u_out !== 16'sd0) begin bad++; $display("FAIL reset_u_out: got %0d want 0", u_out); end
    total++; if (u_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_flags: u_valid=%b busy=%b want 0 0", u_valid, busy); end
    total++; if (dbg_state !== IDLE || dbg_i_acc !== 32'sd0) begin bad++; $display("FAIL reset_state: state=%0d i_acc=%0d want IDLE 0", dbg_state, dbg_i_acc); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_proportional();
    int busy_bad = 0;
    set_gains(16'sh0100, 16'sh0000, 16'sh0000);
    clear_ctrl();
    setpoint = 16'sd100; meas = 16'sd40; meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    kp = 16'sh0200;  // gain change after accept must not affect this update
    for (int c = 1; c <= 5; c++) begin
      if (busy !== 1'b1 || u_valid !== 1'b0) busy_bad++;
      tick();
    end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL prop_busy_window: %0d bad cycles want 0", busy_bad); end
    total++; if (u_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL prop_cycle6: u_valid=%b busy=%b want 1 0", u_valid, busy); end
    total++; if (u_out !== 16'sd60) begin bad++; $display("FAIL prop_value: got %0d want 60", u_out); end
    tick();
    total++; if (u_valid !== 1'b0 || u_out !== 16'sd60) begin bad++; $display("FAIL prop_hold: u_valid=%b u_out=%0d want 0 60", u_valid, u_out); end
  endtask

  task automatic test_integral();
    logic signed [15:0] u;
    int lat;
    logic signed [15:0] exp_u [3] = '{16'sd5, 16'sd10, 16'sd15};
    set_gains(16'sh0000, 16'sh0080, 16'sh0000);
    clear_ctrl();
    for (int k = 0; k < 3; k++) begin
      sample(16'sd10, 16'sd0, u, lat);
      total++; if (lat !== 6 || u !== exp_u[k]) begin bad++; $display("FAIL integral_%0d: u=%0d lat=%0d want %0d 6", k, u, lat, exp_u[k]); end
    end
    enable = 1'b0;
    tick();
    total++; if (u_out !== 16'sd0 || dbg_i_acc !== 32'sd0) begin bad++; $display("FAIL integral_disable: u_out=%0d i_acc=%0d want 0 0", u_out, dbg_i_acc); end
    enable = 1'b1;
    sample(16'sd10, 16'sd0, u, lat);
    total++; if (lat !== 6 || u !== 16'sd5) begin bad++; $display("FAIL integral_restart: u=%0d lat=%0d want 5 6", u, lat); end
  endtask

  task automatic test_derivative();
    logic signed [15:0] u;
    int lat;
    set_gains(16'sh0000, 16'sh0000, 16'sh0200);
    clear_ctrl();
    sample(16'sd10, 16'sd0, u, lat);
    total++; if (lat !== 6 || u !== 16'sd20) begin bad++; $display("FAIL deriv_first: u=%0d lat=%0d want 20 6", u, lat); end
    sample(16'sd30, 16'sd0, u, lat);
    total++; if (lat !== 6 || u !== 16'sd40) begin bad++; $display("FAIL deriv_second: u=%0d lat=%0d want 40 6", u, lat); end
  endtask

  task automatic test_arith_shift();
    logic signed [15:0] u;
    int lat;
    // e=-3, kp=0.5: -384 >>> 8 floors to -2
    set_gains(16'sh0080, 16'sh0000, 16'sh0000);
    clear_ctrl();
    sample(16'sd0, 16'sd3, u, lat);
    total++; if (lat !== 6 || u !== -16'sd2) begin bad++; $display("FAIL arith_floor: u=%0d lat=%0d want -2 6", u, lat); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] u;
    int lat;
    set_gains(16'sh7FFF, 16'sh0000, 16'sh0000);
    clear_ctrl();
    sample(16'sd1000, 16'sd0, u, lat);
    total++; if (u !== 16'sh7FFF) begin bad++; $display("FAIL sat_out_high: got %0h want 7fff", u); end
    sample(16'sd1000, 16'sd2000, u, lat);
    total++; if (u !== 16'sh8000) begin bad++; $display("FAIL sat_out_low: got %0h want 8000", u); end
    set_gains(16'sh0100, 16'sh0000, 16'sh0000);
    clear_ctrl();
    sample(16'sh7FFF, 16'sh8000, u, lat);
    total++; if (u !== 16'sh7FFF) begin bad++; $display("FAIL sat_err_high: got %0h want 7fff", u); end
    sample(16'sh8000, 16'sh7FFF, u, lat);
    total++; if (u !== 16'sh8000) begin bad++; $display("FAIL sat_err_low: got %0h want 8000", u); end
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    set_gains(16'sh0100, 16'sh0000, 16'sh0000);
    clear_ctrl();
    setpoint = 16'sd100; meas = 16'sd40; meas_valid = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      meas_valid = (c == 2 || c == 4);
      meas       = meas_valid ? 16'sd0 : 16'sd40;
      if (u_valid) extra++;
      tick();
    end
    total++; if (u_valid !== 1'b1 || u_out !== 16'sd60) begin bad++; $display("FAIL b2b_first: u_valid=%b u_out=%0d want 1 60", u_valid, u_out); end
    meas = 16'sd50; meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    for (int c = 7; c <= 11; c++) begin
      if (u_valid) extra++;
      tick();
    end
    total++; if (extra != 0) begin bad++; $display("FAIL b2b_extra_valid: got %0d want 0", extra); end
    total++; if (u_valid !== 1'b1 || u_out !== 16'sd50) begin bad++; $display("FAIL b2b_second: u_valid=%b u_out=%0d want 1 50", u_valid, u_out); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] u;
    int lat;
    int seen = 0;
    set_gains(16'sh0100, 16'sh0000, 16'sh0000);
    clear_ctrl();
    sample(16'sd100, 16'sd40, u, lat);
    total++; if (u !== 16'sd60 || dbg_i_acc !== 32'sd60) begin bad++; $display("FAIL rst_mid_pre: u=%0d i_acc=%0d want 60 60", u, dbg_i_acc); end
    tick();
    setpoint = 16'sd100; meas = 16'sd40; meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (u_valid) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_valid: got %0d pulses want 0", seen); end
    total++; if (u_out !== 16'sd0 || dbg_i_acc !== 32'sd0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_after: u_out=%0d i_acc=%0d busy=%b want 0 0 0", u_out, dbg_i_acc, busy); end
    // reset and strobe in the same cycle: reset wins
    reset = 1'b1; meas_valid = 1'b1;
    tick();
    reset = 1'b0; meas_valid = 1'b0;
    total++; if (busy !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL rst_vs_strobe: busy=%b state=%0d want 0 IDLE", busy, dbg_state); end
  endtask

  task automatic test_enable_abort();
    logic signed [15:0] u;
    int lat;
    int seen = 0;
    set_gains(16'sh0100, 16'sh0000, 16'sh0000);
    clear_ctrl();
    sample(16'sd100, 16'sd40, u, lat);
    tick();
    setpoint = 16'sd100; meas = 16'sd40; meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || u_out !== 16'sd0 || dbg_i_acc !== 32'sd0) begin bad++; $display("FAIL abort_clear: busy=%b u_out=%0d i_acc=%0d want 0 0 0", busy, u_out, dbg_i_acc); end
    meas_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (u_valid || busy) seen++;
      tick();
    end
    meas_valid = 1'b0;
    enable = 1'b1;
    total++; if (seen != 0) begin bad++; $display("FAIL abort_ignored: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_antiwindup();
    logic signed [15:0] u;
    int lat;
    logic signed [31:0] exp_i;
`ifdef PID_ANTIWINDUP_EN
    exp_i = 32'sd1000;
`else
    exp_i = 32'sd3000;
`endif
    set_gains(16'sh0000, 16'sh7FFF, 16'sh0000);
    clear_ctrl();
    for (int k = 0; k < 3; k++) begin
      sample(16'sd1000, 16'sd0, u, lat);
      total++; if (u !== 16'sh7FFF) begin bad++; $display("FAIL windup_out_%0d: got %0h want 7fff", k, u); end
    end
    total++; if (dbg_i_acc !== exp_i) begin bad++; $display("FAIL windup_i_acc: got %0d want %0d", dbg_i_acc, exp_i); end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_arith_shift();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_enable_abort();
    test_antiwindup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
